// File: rtl/msx_mouse_port.sv
// msx_mouse_port: MSX mouse-protocol encoder for a single joystick port.
//
// Host mouse deltas are scaled, saturated to 8 bits and held in per-axis
// accumulators. The MSX side reads them as four nibbles, each one requested
// by a level change on the PSG strobe pin (stra):
//   index 0: snapshot taken, tx_x[7:4] driven (tx_x = sat8(-acc_x), tx_y = acc_y)
//   index 1: tx_x[3:0]    index 2: tx_y[7:4]    index 3: tx_y[3:0]
// If no strobe edge arrives for TIMEOUT cycles the index falls back to 0 so
// the next read starts a fresh packet.
//
// Build option:
//   MSX_MOUSE_ACCUM_EN  defined   : each mouse_strobe adds into the accumulator
//                                   (acc = sat8(acc + s)), motion is summed.
//                       undefined : each mouse_strobe overwrites the accumulator
//                                   (acc = sat8(s)), only the latest delta counts.
//
// Parameters:
//   DELTA_W  width of the signed host deltas
//   SCALE    arithmetic right shift applied to each delta before saturation
//   TIMEOUT  idle cycles (no stra edge) before the nibble index returns to 0
//   NIB_REV  1: mouse_out[3:0] = {n[0],n[1],n[2],n[3]}; 0: mouse_out[3:0] = n
//
// Ports:
//   clk_sys       system clock, rising edge
//   reset         synchronous active-high reset
//   mouse_x       signed X delta (positive = right)
//   mouse_y       signed Y delta, passed through unnegated
//   mouse_flags   buttons [0]=left [1]=right, 1 = pressed
//   mouse_strobe  one-cycle pulse qualifying mouse_x/mouse_y/mouse_flags
//   stra          PSG strobe pin; every level change requests the next nibble
//   joy_active    a real joystick is being used on this port
//   mouse_en      port is in mouse mode
//   mouse_out     [3:0] nibble, [5:4] buttons; active-low (1 = released)
//   nib_idx       current nibble index

module msx_mouse_port #(
  parameter int unsigned DELTA_W = 9,
  parameter int unsigned SCALE   = 1,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned NIB_REV = 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [DELTA_W-1:0] mouse_x,
  input  logic [DELTA_W-1:0] mouse_y,
  input  logic [1:0]         mouse_flags,
  input  logic               mouse_strobe,
  input  logic               stra,
  input  logic               joy_active,
  output logic               mouse_en,
  output logic [5:0]         mouse_out,
  output logic [1:0]         nib_idx
);

  // One bit wider than the widest operand so acc + s can never wrap.
  localparam int unsigned SumW = ((DELTA_W > 8) ? DELTA_W : 8) + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  localparam logic signed [SumW-1:0] SatMax     = SumW'(127);
  localparam logic signed [SumW-1:0] SatMin     = -SumW'(128);
  localparam logic [CntW-1:0]        TimeoutVal = CntW'(TIMEOUT);
  localparam logic [CntW-1:0]        CntOne     = CntW'(1);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [SumW-1:0] ext_delta(input logic signed [DELTA_W-1:0] v);
    return {{(SumW - DELTA_W){v[DELTA_W-1]}}, v};
  endfunction

  function automatic logic signed [SumW-1:0] ext_acc(input logic [7:0] v);
    return {{(SumW - 8){v[7]}}, v};
  endfunction

  function automatic logic [7:0] sat8(input logic signed [SumW-1:0] v);
    if (v > SatMax) return 8'h7F;
    if (v < SatMin) return 8'h80;
    return v[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            mouse_en_q, mouse_en_d;
  logic            stra_q;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      nib_q, nib_d;
  logic [1:0]      btn_q;
  logic [7:0]      acc_x_q, acc_x_d;
  logic [7:0]      acc_y_q, acc_y_d;
  logic [7:0]      tx_x_q, tx_x_d;
  logic [7:0]      tx_y_q, tx_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic signed [DELTA_W-1:0] s_x, s_y;
  logic                      strobe_edge;
  logic                      shift;
  logic                      snapshot;
  logic [3:0]                nib_sel;

  assign s_x = $signed(mouse_x) >>> SCALE;
  assign s_y = $signed(mouse_y) >>> SCALE;

  assign strobe_edge = stra ^ stra_q;
  assign shift       = strobe_edge & mouse_en_q;
  assign snapshot    = shift && (idx_q == 2'd0);

  // ---------------------------------------------------------------------------
  // Mode select: a mouse report claims the port, joystick use releases it.
  // ---------------------------------------------------------------------------
  always_comb begin
    mouse_en_d = mouse_en_q;
    if (mouse_strobe) begin
      mouse_en_d = 1'b1;
    end else if (joy_active) begin
      mouse_en_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators and transmit snapshot
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_x_d  = tx_x_q;
    tx_y_d  = tx_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;

    if (snapshot) begin
      // X is reported negated; -(-128) saturates to +127.
      tx_x_d  = sat8(-ext_acc(acc_x_q));
      tx_y_d  = acc_y_q;
      acc_x_d = 8'h00;
      acc_y_d = 8'h00;
    end

    // Intake after the snapshot clear so a coincident report lands in the
    // fresh accumulator instead of being dropped.
    if (mouse_strobe) begin
`ifdef MSX_MOUSE_ACCUM_EN
      acc_x_d = sat8(ext_acc(acc_x_d) + ext_delta(s_x));
      acc_y_d = sat8(ext_acc(acc_y_d) + ext_delta(s_y));
`else
      acc_x_d = sat8(ext_delta(s_x));
      acc_y_d = sat8(ext_delta(s_y));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble sequencer and inactivity timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    nib_sel = 4'hF;
    unique case (idx_q)
      2'd0: nib_sel = tx_x_d[7:4];  // uses the snapshot taken this cycle
      2'd1: nib_sel = tx_x_q[3:0];
      2'd2: nib_sel = tx_y_q[7:4];
      2'd3: nib_sel = tx_y_q[3:0];
    endcase
  end

  always_comb begin
    nib_d = nib_q;
    idx_d = idx_q;
    cnt_d = cnt_q;

    if (!mouse_en_d) begin
      // Leaving (or staying out of) mouse mode parks the sequencer.
      nib_d = 4'hF;
      idx_d = 2'd0;
      cnt_d = '0;
    end else if (shift) begin
      nib_d = (NIB_REV != 0) ? {nib_sel[0], nib_sel[1], nib_sel[2], nib_sel[3]} : nib_sel;
      idx_d = idx_q + 2'd1;
      cnt_d = TimeoutVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        idx_d = 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mouse_en_q <= 1'b0;
      stra_q     <= stra;  // no phantom edge when reset releases
      idx_q      <= 2'd0;
      nib_q      <= 4'hF;
      btn_q      <= 2'b11;
      acc_x_q    <= 8'h00;
      acc_y_q    <= 8'h00;
      tx_x_q     <= 8'h00;
      tx_y_q     <= 8'h00;
      cnt_q      <= '0;
    end else begin
      mouse_en_q <= mouse_en_d;
      stra_q     <= stra;
      idx_q      <= idx_d;
      nib_q      <= nib_d;
      btn_q      <= ~mouse_flags;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      tx_x_q     <= tx_x_d;
      tx_y_q     <= tx_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mouse_en  = mouse_en_q;
  assign mouse_out = {btn_q, nib_q};
  assign nib_idx   = idx_q;

endmodule
